cipher_seq_ctrl: RTL and testbench

Sequencing controller for the cipher pipeline, between the keyboard front end (scan code to ASCII) and the encrypt datapath / VGA character writer. It captures a one-byte key and a plaintext message into an internal buffer, driven by Enter presses. It then feeds each buffered character through the datapath and forwards every result to the VGA writer under a valid/ready handshake. It replaces the free-running FSM-plus-toggle-clock arrangement with a single-clock, handshake-driven controller.

---
 rtl/cipher_pkg.sv | 18 +
 rtl/cipher_char_buf.sv | 48 ++++
 rtl/cipher_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_cipher_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher sequencing controller.
package cipher_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY      = 3'd1,
        MSG      = 3'd2,
        ENC      = 3'd3,
        WAIT_ENC = 3'd4,
        SHOW     = 3'd5,
        WAIT_VGA = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [7:0] ASCII_BKSP    = 8'h08;
    localparam int         DEPTH_DEFAULT = 32;

endpackage

// File: rtl/cipher_char_buf.sv
// Message buffer: DEPTH x 8 register file with a fill count, full flag and backspace.
// Writes append at the current count; the read port is combinational.
module cipher_char_buf
    import cipher_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr,
    input  logic          bksp,
    input  logic          clr,
    input  logic [7:0]    wr_data,
    input  logic [CW-2:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic          full
);

    logic [7:0] mem [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_addr];

    // count_nxt is exported so the FSM can decide on the post-write count in the same cycle
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (bksp) begin
            if (count != '0) count_nxt = count - CW'(1);
        end else if (wr && !full) begin
            count_nxt = count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) count <= '0;
        else         count <= count_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr && !full && !clr && !bksp) mem[count[CW-2:0]] <= wr_data;
    end

endmodule

// File: rtl/cipher_seq_ctrl.sv
// Cipher sequencing controller: key/message capture, per-character encrypt and VGA handshake.
// Optional macro CIPHER_BKSP_EN: 8'h08 in MSG acts as backspace instead of a stored character.
//
// state    | meaning
// IDLE     | waiting for Enter to begin
// KEY      | typed characters overwrite the key byte; Enter (with a key) moves on
// MSG      | typed characters are appended to the buffer; Enter starts encryption
// ENC      | present buf[rd_ptr] to the datapath and pulse enc_start
// WAIT_ENC | wait for enc_valid, capture result
// SHOW     | offer vga_char until vga_ready
// WAIT_VGA | reserved, never entered
// DONE     | all characters shown; Enter returns to IDLE
module cipher_seq_ctrl
    import cipher_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enter_n,
    input  logic          kb_valid,
    input  logic [7:0]    kb_ascii,
    output logic          enc_start,
    output logic [7:0]    enc_char,
    output logic [7:0]    enc_key,
    input  logic          enc_valid,
    input  logic [7:0]    enc_result,
    output logic          vga_go,
    output logic [7:0]    vga_char,
    input  logic          vga_ready,
    output logic [2:0]    state,
    output logic [CW-1:0] buf_count,
    output logic          overflow
);

    state_t        state_r;
    logic          sync0, sync1, sync2, enter_p;
    logic          key_ok, is_bksp;
    logic [CW-1:0] rd_ptr, count_nxt;
    logic [7:0]    buf_rd;
    logic          buf_full, kb_msg, buf_wr, buf_bksp, buf_clr;

`ifdef CIPHER_BKSP_EN
    assign is_bksp = (kb_ascii == ASCII_BKSP);
`else
    assign is_bksp = 1'b0;
`endif

    assign kb_msg   = (state_r == MSG) && kb_valid;
    assign buf_wr   = kb_msg && !is_bksp;
    assign buf_bksp = kb_msg && is_bksp;
    assign buf_clr  = (state_r == DONE) && enter_p;
    assign state    = state_r;

    cipher_char_buf #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .wr        (buf_wr),
        .bksp      (buf_bksp),
        .clr       (buf_clr),
        .wr_data   (kb_ascii),
        .rd_addr   (rd_ptr[CW-2:0]),
        .rd_data   (buf_rd),
        .count     (buf_count),
        .count_nxt (count_nxt),
        .full      (buf_full)
    );

    // Enter synchronizer; flops idle high so reset release never looks like a press
    always_ff @(posedge clk) begin
        if (!resetn) begin
            {sync0, sync1, sync2} <= 3'b111;
            enter_p               <= 1'b0;
        end else begin
            sync0   <= enter_n;
            sync1   <= sync0;
            sync2   <= sync1;
            enter_p <= sync2 & ~sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= IDLE;
            enc_start <= 1'b0;
            enc_char  <= '0;
            enc_key   <= '0;
            vga_go    <= 1'b0;
            vga_char  <= '0;
            overflow  <= 1'b0;
            key_ok    <= 1'b0;
            rd_ptr    <= '0;
        end else begin
            enc_start <= 1'b0;
            case (state_r)
                IDLE: if (enter_p) state_r <= KEY;
                KEY: begin
                    if (kb_valid) begin
                        enc_key <= kb_ascii;
                        key_ok  <= 1'b1;
                    end
                    if (enter_p && key_ok) state_r <= MSG;
                end
                MSG: begin
                    if (buf_wr && buf_full) overflow <= 1'b1;
                    if (enter_p) begin
                        rd_ptr  <= '0;
                        state_r <= (count_nxt != '0) ? ENC : DONE;
                    end
                end
                ENC: begin
                    enc_char  <= buf_rd;
                    enc_start <= 1'b1;
                    state_r   <= WAIT_ENC;
                end
                WAIT_ENC: if (enc_valid) begin
                    vga_char <= enc_result;
                    vga_go   <= 1'b1;
                    state_r  <= SHOW;
                end
                SHOW: if (vga_ready) begin
                    vga_go  <= 1'b0;
                    rd_ptr  <= rd_ptr + CW'(1);
                    state_r <= ((rd_ptr + CW'(1)) == buf_count) ? DONE : ENC;
                end
                DONE: if (enter_p) begin
                    state_r  <= IDLE;
                    rd_ptr   <= '0;
                    key_ok   <= 1'b0;
                    overflow <= 1'b0;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Self-checking bench for cipher_seq_ctrl: table of sessions, directed corner cases, random sessions.
module tb_cipher_seq_ctrl;

    localparam int DEPTH = 32;
    localparam int CW    = 6;
    localparam logic [2:0] S_IDLE = 3'd0, S_KEY = 3'd1, S_MSG = 3'd2;
    localparam logic [2:0] S_WAIT_ENC = 3'd4, S_SHOW = 3'd5, S_DONE = 3'd7;

    logic          clk = 1'b0;
    logic          resetn = 1'b0, enter_n = 1'b1, kb_valid = 1'b0;
    logic [7:0]    kb_ascii = 8'h00;
    logic          enc_valid, vga_ready;
    logic [7:0]    enc_result;
    logic          enc_start, vga_go, overflow;
    logic [7:0]    enc_char, enc_key, vga_char;
    logic [2:0]    state;
    logic [CW-1:0] buf_count;

    cipher_seq_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .enter_n(enter_n), .kb_valid(kb_valid), .kb_ascii(kb_ascii),
        .enc_start(enc_start), .enc_char(enc_char), .enc_key(enc_key), .enc_valid(enc_valid),
        .enc_result(enc_result), .vga_go(vga_go), .vga_char(vga_char), .vga_ready(vga_ready),
        .state(state), .buf_count(buf_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_pass = 0, n_total = 0, n_start = 0;
    logic [7:0] got_q[$], msg_q[$], exp_q[$];
    int         dp_lat = 2, dp_cnt = -1;
    bit         dp_xor = 0, ready_block = 0, ready_rand = 0;
    logic [7:0] dp_char, dp_k;

    // Datapath and VGA writer models, plus transfer/start monitors
    always @(negedge clk) begin
        enc_valid = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
                enc_valid  = 1'b1;
                enc_result = dp_xor ? (dp_char ^ dp_k) : (dp_char + 8'd1);
                dp_cnt     = -1;
            end
        end
        if (enc_start) begin
            dp_char = enc_char;
            dp_k    = enc_key;
            dp_cnt  = dp_lat;
            n_start++;
        end
        vga_ready = ready_block ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (vga_go && vga_ready) got_q.push_back(vga_char);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_enter();
        enter_n = 1'b0;
        tick(6);
        enter_n = 1'b1;
        tick(5);
    endtask

    task automatic type_char(input logic [7:0] c);
        kb_valid = 1'b1;
        kb_ascii = c;
        tick(1);
        kb_valid = 1'b0;
        tick(1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        check(name, state, s);
    endtask

    // Expected ciphertext from the plaintext typed, using buffer rules (drop when full, backspace)
    function automatic void build_model(input logic [7:0] key, output int cnt, output bit ovf);
        logic [7:0] mq[$];
        bit         is_bs;
        ovf = 0;
        exp_q.delete();
        foreach (msg_q[i]) begin
            is_bs = 0;
`ifdef CIPHER_BKSP_EN
            is_bs = (msg_q[i] == 8'h08);
`endif
            if (is_bs) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else if (mq.size() < DEPTH) mq.push_back(msg_q[i]);
            else ovf = 1;
        end
        cnt = mq.size();
        foreach (mq[i]) exp_q.push_back(dp_xor ? (mq[i] ^ key) : (mq[i] + 8'd1));
    endfunction

    task automatic run_session(input logic [7:0] key, input int exp_cnt, input bit exp_ovf,
                               input bit hold, input bit dbl, input string tag);
        int m_cnt;
        bit m_ovf, stable;
        build_model(key, m_cnt, m_ovf);
        got_q.delete();
        n_start = 0;
        press_enter();
        check($sformatf("%s_key_state", tag), state, S_KEY);
        if (dbl) begin
            press_enter();
            check($sformatf("%s_nokey_enter", tag), state, S_KEY);
        end
        type_char(key);
        press_enter();
        check($sformatf("%s_msg_state", tag), state, S_MSG);
        foreach (msg_q[i]) type_char(msg_q[i]);
        check($sformatf("%s_count", tag), buf_count, exp_cnt);
        check($sformatf("%s_overflow", tag), overflow, exp_ovf);
        check($sformatf("%s_enc_key", tag), enc_key, key);
        ready_block = hold;
        press_enter();
        if (hold) begin
            wait_state(S_SHOW, 40, $sformatf("%s_reach_show", tag));
            stable = 1;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                if (!(vga_go === 1'b1 && vga_char === exp_q[0])) stable = 0;
            end
            check($sformatf("%s_hold_stable", tag), stable, 1'b1);
            check($sformatf("%s_hold_no_xfer", tag), got_q.size(), 0);
            ready_block = 0;
        end
        wait_state(S_DONE, 30 * exp_cnt + 60, $sformatf("%s_done", tag));
        check($sformatf("%s_xfers", tag), got_q.size(), exp_q.size());
        check($sformatf("%s_starts", tag), n_start, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_char%0d", tag, i),
                  (i < got_q.size()) ? {56'h0, got_q[i]} : 64'hDEAD, {56'h0, exp_q[i]});
        press_enter();
        check($sformatf("%s_back_idle", tag), state, S_IDLE);
        check($sformatf("%s_cleared", tag), {buf_count, overflow}, 0);
    endtask

    typedef struct {
        logic [7:0] key;
        int         len;
        logic [7:0] base;
        int         exp_cnt;
        bit         exp_ovf;
        bit         dbl;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   r_cnt, bk_cnt;
        bit   r_ovf;
        logic [7:0] key;

        vecs[0] = '{8'h4B, 2,         8'h41, 2,     1'b0, 1'b0};
        vecs[1] = '{8'h10, 0,         8'h00, 0,     1'b0, 1'b1};
        vecs[2] = '{8'h55, DEPTH + 2, 8'h30, DEPTH, 1'b1, 1'b0};
        vecs[3] = '{8'h01, DEPTH,     8'h60, DEPTH, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1,         8'h7E, 1,     1'b0, 1'b0};

        tick(3);
        check("reset_state", state, S_IDLE);
        check("reset_outs", {enc_start, enc_char, enc_key, vga_go, vga_char, buf_count, overflow}, 0);
        resetn = 1'b1;
        tick(2);
        check("idle_after_release", state, S_IDLE);

        foreach (vecs[v]) begin
            msg_q.delete();
            for (int i = 0; i < vecs[v].len; i++) msg_q.push_back(vecs[v].base + 8'(i));
            run_session(vecs[v].key, vecs[v].exp_cnt, vecs[v].exp_ovf, 1'b0, vecs[v].dbl,
                        $sformatf("vec%0d", v));
        end

        dp_lat = 1;
        msg_q = '{8'h5A, 8'h61};
        run_session(8'h22, 2, 1'b0, 1'b1, 1'b0, "hold");

`ifdef CIPHER_BKSP_EN
        bk_cnt = 2;
`else
        bk_cnt = 4;
`endif
        msg_q = '{8'h41, 8'h42, 8'h08, 8'h43};
        run_session(8'h33, bk_cnt, 1'b0, 1'b0, 1'b0, "bksp");

        // Reset while waiting on the datapath; its late enc_valid must be ignored
        dp_lat = 8;
        got_q.delete();
        press_enter();
        type_char(8'h77);
        press_enter();
        type_char(8'h51);
        press_enter();
        wait_state(S_WAIT_ENC, 20, "rst_reach_wait_enc");
        resetn = 1'b0;
        tick(1);
        check("rst_mid_state", state, S_IDLE);
        check("rst_mid_outs", {enc_start, enc_char, enc_key, vga_go, vga_char, buf_count, overflow}, 0);
        resetn = 1'b1;
        tick(12);
        check("rst_late_valid_state", state, S_IDLE);
        check("rst_late_valid_go", {vga_go, vga_char}, 0);
        check("rst_no_xfer", got_q.size(), 0);

        dp_xor = 1;
        ready_rand = 1;
        for (int s = 0; s < 6; s++) begin
            int len;
            key = 8'($urandom);
            len = $urandom_range(0, DEPTH + 3);
            msg_q.delete();
            for (int i = 0; i < len; i++)
                msg_q.push_back(($urandom_range(0, 9) == 0) ? 8'h08 : 8'(8'h20 + $urandom_range(0, 90)));
            dp_lat = $urandom_range(1, 3);
            build_model(key, r_cnt, r_ovf);
            run_session(key, r_cnt, r_ovf, 1'b0, 1'b0, $sformatf("rnd%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
